// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - instruction handshake, ALU issue slot and result tag bundle
interface alu_issue_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_opcode;
  logic [2:0] in_rs1;
  logic [2:0] in_rs2;
  logic [2:0] in_rd;
  logic [3:0] alu_opcode;
  logic [2:0] alu_rs1;
  logic [2:0] alu_rs2;
  logic [2:0] alu_rd;
  logic       res_valid;
  logic [2:0] res_rd;

  modport master (
    output in_valid, in_opcode, in_rs1, in_rs2, in_rd,
    input  in_ready, alu_opcode, alu_rs1, alu_rs2, alu_rd, res_valid, res_rd
  );

  modport slave (
    input  in_valid, in_opcode, in_rs1, in_rs2, in_rd,
    output in_ready, alu_opcode, alu_rs1, alu_rs2, alu_rd, res_valid, res_rd
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - in-order issue queue with RAW interlock for a 3-stage ALU
module alu_issue_ctrl #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  alu_issue_ctrl_if.slave  bus,
  output logic             idle,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] stall_count
);
  localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [3:0]  OP_PASS_A = 4'd8;

  // Entries and slots are packed as {opcode, rs1, rs2, rd}.
  logic [12:0]      mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             full, empty, push, pop;

  logic [12:0]      head, slot_q, slot_d;
  logic [3:0]       head_op;
  logic [2:0]       head_rs1, head_rs2, head_rd;
  logic             use_rs1, use_rs2, rs1_hit, rs2_hit, stall, issue;
  logic [2:0]       bubble_rd;

  logic             slot_v_q, hist_v_q, res_v_q;
  logic [2:0]       hist_rd_q, res_rd_q;
  logic [CNT_W-1:0] instr_cnt_q, stall_cnt_q;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign push  = bus.in_valid && !full;
  assign pop   = issue;

  assign head = mem_q[rd_ptr_q];
  assign {head_op, head_rs1, head_rs2, head_rd} = head;

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (head_op)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      4'd6, 4'd8, 4'd10, 4'd11: use_rs1 = 1'b1;
      4'd7, 4'd9:               use_rs2 = 1'b1;
      default: ;
    endcase
  end

  // slot_q is the slot loaded at the previous edge, hist_* the one before it.
  assign rs1_hit = (slot_v_q && head_rs1 == slot_q[2:0]) || (hist_v_q && head_rs1 == hist_rd_q);
  assign rs2_hit = (slot_v_q && head_rs2 == slot_q[2:0]) || (hist_v_q && head_rs2 == hist_rd_q);
  assign stall   = !empty && ((use_rs1 && rs1_hit) || (use_rs2 && rs2_hit));
  assign issue   = !empty && !stall;

  // At most two registers are excluded, so the answer always lies in R0..R2.
  always_comb begin
    bubble_rd = 3'd0;
    for (int i = 2; i >= 0; i--) begin
      if (!(slot_v_q && slot_q[2:0] == 3'(i)) && !(hist_v_q && hist_rd_q == 3'(i)))
        bubble_rd = 3'(i);
    end
  end

  always_comb begin
    slot_d = {OP_PASS_A, bubble_rd, bubble_rd, bubble_rd};
    if (issue)
      slot_d = head;
  end

  assign count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= {bus.in_opcode, bus.in_rs1, bus.in_rs2, bus.in_rd};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      slot_q      <= {OP_PASS_A, 9'd0};
      slot_v_q    <= 1'b0;
      hist_v_q    <= 1'b0;
      hist_rd_q   <= 3'd0;
      res_v_q     <= 1'b0;
      res_rd_q    <= 3'd0;
      instr_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (push)
        wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)
        rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q   <= count_d;
      slot_q    <= slot_d;
      slot_v_q  <= issue;
      hist_v_q  <= slot_v_q;
      hist_rd_q <= slot_q[2:0];
      res_v_q   <= hist_v_q;
      res_rd_q  <= hist_rd_q;
      if (issue)
        instr_cnt_q <= instr_cnt_q + 1'b1;
      if (stall)
        stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign bus.in_ready = !full;
  assign {bus.alu_opcode, bus.alu_rs1, bus.alu_rs2, bus.alu_rd} = slot_q;
  assign bus.res_valid = res_v_q;
  assign bus.res_rd    = res_rd_q;
  assign idle          = empty && !slot_v_q && !hist_v_q && !res_v_q;
  assign instr_count   = instr_cnt_q;
  assign stall_count   = stall_cnt_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - scoreboard bench with issue-time reference model and ALU register-file model
module tb_alu_issue_ctrl;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int TMO   = 300;

  typedef struct {
    logic [3:0] op;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [2:0] rd;
    int         enq;
  } instr_t;

  typedef struct {
    int         t;
    logic [2:0] rd;
  } iss_t;

  logic             clk   = 1'b0;
  logic             reset = 1'b1;
  logic             idle;
  logic [CNT_W-1:0] instr_count, stall_count;

  alu_issue_ctrl_if bus();

  alu_issue_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .idle        (idle),
    .instr_count (instr_count),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc   = 0;
  int         exp_instr, exp_stall;
  bit         saw_block;
  instr_t     sbq[$];
  iss_t       iss[$];
  logic [2:0] res_log[$];
  logic [7:0] gold [8];
  logic [7:0] arf [8];
  logic [7:0] pw_val [3];
  logic [2:0] pw_rd [3];
  logic       pw_v [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a * b;
      4'd3:    return a & b;
      4'd4:    return a | b;
      4'd5:    return a ^ b;
      4'd6:    return ~a;
      4'd7:    return ~b;
      4'd8:    return a;
      4'd9:    return b;
      4'd10:   return a >> 1;
      4'd11:   return a << 1;
      default: return 8'h00;
    endcase
  endfunction

  function automatic bit uses(input instr_t i, input logic [2:0] r);
    bit u1, u2;
    u1 = 1'b0;
    u2 = 1'b0;
    case (i.op)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5: begin u1 = 1'b1; u2 = 1'b1; end
      4'd6, 4'd8, 4'd10, 4'd11: u1 = 1'b1;
      4'd7, 4'd9: u2 = 1'b1;
      default: ;
    endcase
    return (u1 && i.rs1 == r) || (u2 && i.rs2 == r);
  endfunction

  function automatic void model_clear();
    sbq.delete();
    iss.delete();
    exp_instr = 0;
    exp_stall = 0;
    for (int i = 0; i < 8; i++) begin
      gold[i] = 8'(i * 37 + 5);
      arf[i]  = gold[i];
    end
    for (int i = 0; i < 3; i++) begin
      pw_v[i]   = 1'b0;
      pw_rd[i]  = 3'd0;
      pw_val[i] = 8'd0;
    end
  endfunction

  // Reference: an instruction issues at the first edge after both its enqueue and its
  // predecessor's issue, and no earlier than 3 edges after either of the two previous
  // real issues whose destination it reads.
  task automatic mon_edge();
    int          t, e;
    bit          do_iss, do_stall, exp_rv, exp_idle, busy;
    logic [2:0]  rb, exp_rrd;
    logic [12:0] exp_slot;
    instr_t      h;
    iss_t        s;
    t        = cyc;
    do_iss   = 1'b0;
    do_stall = 1'b0;
    if (sbq.size() > 0) begin
      h = sbq[0];
      e = h.enq + 1;
      if (iss.size() > 0) begin
        s = iss[iss.size()-1];
        if (s.t + 1 > e) e = s.t + 1;
        if (s.t + 3 > e && uses(h, s.rd)) e = s.t + 3;
      end
      if (iss.size() > 1) begin
        s = iss[iss.size()-2];
        if (s.t + 3 > e && uses(h, s.rd)) e = s.t + 3;
      end
      do_iss   = (e <= t);
      do_stall = !do_iss && (h.enq + 1 <= t);
    end

    rb = 3'd0;
    for (int r = 7; r >= 0; r--) begin
      busy = 1'b0;
      foreach (iss[k])
        if (iss[k].t >= t - 2 && iss[k].t <= t - 1 && iss[k].rd == 3'(r)) busy = 1'b1;
      if (!busy) rb = 3'(r);
    end

    exp_slot = do_iss ? {h.op, h.rs1, h.rs2, h.rd} : {4'd8, rb, rb, rb};
    check("slot", 32'({bus.alu_opcode, bus.alu_rs1, bus.alu_rs2, bus.alu_rd}), 32'(exp_slot));

    if (do_iss) begin
      s.t  = t;
      s.rd = h.rd;
      iss.push_back(s);
      void'(sbq.pop_front());
      exp_instr++;
      if (iss.size() > 4) void'(iss.pop_front());
    end
    if (do_stall) exp_stall++;

    exp_rv  = 1'b0;
    exp_rrd = 3'd0;
    foreach (iss[k])
      if (iss[k].t == t - 2) begin exp_rv = 1'b1; exp_rrd = iss[k].rd; end
    check("res_valid", 32'(bus.res_valid), 32'(exp_rv));
    if (exp_rv) check("res_rd", 32'(bus.res_rd), 32'(exp_rrd));
    if (bus.res_valid) res_log.push_back(bus.res_rd);

    check("counters", 32'({instr_count, stall_count}), 32'({CNT_W'(exp_instr), CNT_W'(exp_stall)}));
    check("in_ready", 32'(bus.in_ready), 32'(sbq.size() < DEPTH));

    exp_idle = (sbq.size() == 0);
    foreach (iss[k])
      if (iss[k].t >= t - 2) exp_idle = 1'b0;
    check("idle", 32'(idle), 32'(exp_idle));

    // Downstream ALU: a slot reads operands when loaded and writes back 3 edges later.
    if (pw_v[2]) arf[pw_rd[2]] = pw_val[2];
    for (int i = 2; i > 0; i--) begin
      pw_v[i]   = pw_v[i-1];
      pw_rd[i]  = pw_rd[i-1];
      pw_val[i] = pw_val[i-1];
    end
    pw_v[0]   = 1'b1;
    pw_rd[0]  = bus.alu_rd;
    pw_val[0] = alu_f(bus.alu_opcode, arf[bus.alu_rs1], arf[bus.alu_rs2]);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!reset) begin
        model_clear();
      end else begin
        #1;
        mon_edge();
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [2:0] rs1, input logic [2:0] rs2, input logic [2:0] rd);
    instr_t x;
    int     n;
    n = 0;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_opcode = op;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_rd     = rd;
    while (!bus.in_ready && n < TMO) begin
      saw_block = 1'b1;
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      bus.in_valid = 1'b0;
      check("send_accept", 32'(bus.in_ready), 32'd1);
    end else begin
      x.op  = op;
      x.rs1 = rs1;
      x.rs2 = rs2;
      x.rd  = rd;
      x.enq = cyc + 1;
      sbq.push_back(x);
      gold[rd] = alu_f(op, gold[rs1], gold[rs2]);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_slot"}, 32'({bus.alu_opcode, bus.alu_rs1, bus.alu_rs2, bus.alu_rd}), 32'({4'd8, 9'd0}));
    check({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    check({name, "_idle"}, 32'(idle), 32'd1);
    check({name, "_res_valid"}, 32'(bus.res_valid), 32'd0);
    check({name, "_counters"}, 32'({instr_count, stall_count}), 32'd0);
  endtask

  task automatic apply_reset(input string name);
    @(negedge clk);
    #2;
    bus.in_valid = 1'b0;
    reset = 1'b0;
    model_clear();
    res_log.delete();
    #1;
    check_reset_state(name);
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!idle && n < TMO) begin
      n++;
      @(negedge clk);
    end
    check({name, "_drain_idle"}, 32'(idle), 32'd1);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s_reg%0d", name, i), 32'(arf[i]), 32'(gold[i]));
  endtask

  initial begin
    logic [2:0] want_rd [3];
    bus.in_valid  = 1'b0;
    bus.in_opcode = 4'd0;
    bus.in_rs1    = 3'd0;
    bus.in_rs2    = 3'd0;
    bus.in_rd     = 3'd0;
    saw_block     = 1'b0;
    model_clear();
    #1 reset = 1'b0;
    #1 check_reset_state("por");
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Independent stream
    send(4'd0, 3'd1, 3'd2, 3'd3);
    send(4'd1, 3'd4, 3'd5, 3'd6);
    send(4'd5, 3'd7, 3'd0, 3'd2);
    drain("indep");
    want_rd[0] = 3'd3;
    want_rd[1] = 3'd6;
    want_rd[2] = 3'd2;
    check("indep_res_count", 32'(res_log.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < res_log.size()) check($sformatf("indep_res_rd%0d", i), 32'(res_log[i]), 32'(want_rd[i]));
    check("indep_counts", 32'({instr_count, stall_count}), 32'({4'd3, 4'd0}));

    // RAW hazard
    apply_reset("rst_raw");
    send(4'd0, 3'd1, 3'd2, 3'd3);
    send(4'd3, 3'd3, 3'd0, 3'd4);
    drain("raw");
    check("raw_counts", 32'({instr_count, stall_count}), 32'({4'd2, 4'd2}));

    // Bubble register selection
    apply_reset("rst_bub");
    send(4'd0, 3'd1, 3'd1, 3'd0);
    send(4'd4, 3'd0, 3'd2, 3'd5);
    drain("bub");
    check("bub_r0_doubled", 32'(arf[0]), 32'd84);
    check("bub_stalls", 32'(stall_count), 32'd2);

    // Unused source never stalls
    apply_reset("rst_unary");
    send(4'd0, 3'd1, 3'd1, 3'd2);
    send(4'd9, 3'd2, 3'd3, 3'd6);
    drain("unary");
    check("unary_counts", 32'({instr_count, stall_count}), 32'({4'd2, 4'd0}));

    // Backpressure behind a held hazard
    apply_reset("rst_bp");
    saw_block = 1'b0;
    send(4'd0, 3'd1, 3'd1, 3'd1);
    for (int i = 0; i < DEPTH + 2; i++) send(4'd2, 3'd1, 3'd1, 3'd1);
    drain("bp");
    check("bp_saw_block", 32'(saw_block), 32'd1);
    check("bp_counts", 32'({instr_count, stall_count}), 32'({4'd7, 4'd12}));

    // Randomized traffic, counters wrap past 2^CNT_W
    apply_reset("rst_rand");
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      send(4'($urandom_range(0, 15)), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 3)));
    end
    drain("rand");
    check("rand_instr_wrap", 32'(instr_count), 32'(CNT_W'(80)));

    // Reset while entries are queued and a producer is in flight
    apply_reset("rst_pre");
    send(4'd0, 3'd1, 3'd1, 3'd1);
    for (int i = 0; i < 3; i++) send(4'd2, 3'd1, 3'd1, 3'd1);
    apply_reset("rst_mid");
    repeat (10) @(negedge clk);
    check("mid_no_res_after", 32'(res_log.size()), 32'd0);
    check("mid_idle_after", 32'(idle), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not reach its summary, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
